// File: rtl/spi_cmd_slave_pkg.sv
// Shared constants, MISO field offsets and FSM state type for the SPI command bridge.
// SPI_CMD_PARITY_EN lengthens frames by one trailing even-parity bit in both directions.
// No logic; sizes the frame shifters and decodes the NOP/clear-flags command.
package spi_cmd_slave_pkg;

`ifdef SPI_CMD_PARITY_EN
    localparam int SPI_CMD_FRAME_BITS = 33;
`else
    localparam int SPI_CMD_FRAME_BITS = 32;
`endif

    localparam logic [3:0] SPI_CMD_ADDR_NOP      = 4'hF;
    localparam logic [3:0] SPI_CMD_CTRL_CLRFLAGS = 4'h1;

    localparam int SPI_CMD_MISO_VALID = 31;
    localparam int SPI_CMD_MISO_OVF   = 30;
    localparam int SPI_CMD_MISO_PERR  = 29;

    localparam int SPI_CMD_RSP_W = 28;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/spi_cmd_slave_resp_fifo.sv
// Synchronous FIFO with first-word fall-through head (dout valid whenever !empty).
// Latency: a push is visible at dout the cycle after it is written.
// Backpressure: push while full is ignored unless a pop happens in the same cycle.
module resp_fifo #(
    parameter int WIDTH = 28,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             do_push, do_pop;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, 1'b1};
        if (do_pop)  rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din;
    end

endmodule

// File: rtl/spi_cmd_slave.sv
// SPI-slave command bridge: host frames become cmd_* strobes, queued rsp_* words return on MISO.
// Latency: pin edges act SYNC_STAGES+1 clk later; cmd_wr and FIFO pop one cycle after the last SCK rise is seen.
// Backpressure: none toward the host; replies hitting a full FIFO are dropped and flagged (SPI_CMD_PARITY_EN adds parity).
module spi_cmd_slave
    import spi_cmd_slave_pkg::*;
#(
    parameter int FIFO_DEPTH  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        spi_cs,
    input  logic        spi_clk,
    input  logic        spi_mosi,
    output logic        spi_miso,
    output logic [3:0]  cmd_addr,
    output logic [3:0]  cmd_ctrl,
    output logic [23:0] cmd_data,
    output logic        cmd_wr,
    input  logic [3:0]  rsp_addr,
    input  logic [23:0] rsp_data,
    input  logic        rsp_wr,
    output logic        fifo_ovf
);
    localparam int FB = SPI_CMD_FRAME_BITS;

    // Synchronizers are deliberately not reset so CS level is known while rst is held.
    logic [SYNC_STAGES:0]   cs_sh_q, cs_sh_d, sck_sh_q, sck_sh_d;
    logic [SYNC_STAGES-1:0] mosi_sh_q, mosi_sh_d;

    always_comb begin
        cs_sh_d   = {cs_sh_q[SYNC_STAGES-1:0], spi_cs};
        sck_sh_d  = {sck_sh_q[SYNC_STAGES-1:0], spi_clk};
        mosi_sh_d = {mosi_sh_q[SYNC_STAGES-2:0], spi_mosi};
    end

    always_ff @(posedge clk) begin
        cs_sh_q   <= cs_sh_d;
        sck_sh_q  <= sck_sh_d;
        mosi_sh_q <= mosi_sh_d;
    end

    logic cs_cur, cs_fall, cs_rise, sck_rise, sck_fall, mosi_bit;
    assign cs_cur   = cs_sh_q[SYNC_STAGES-1];
    assign cs_fall  = cs_sh_q[SYNC_STAGES] & ~cs_cur;
    assign cs_rise  = ~cs_sh_q[SYNC_STAGES] & cs_cur;
    assign sck_rise = ~sck_sh_q[SYNC_STAGES] & sck_sh_q[SYNC_STAGES-1];
    assign sck_fall = sck_sh_q[SYNC_STAGES] & ~sck_sh_q[SYNC_STAGES-1];
    assign mosi_bit = mosi_sh_q[SYNC_STAGES-1];

    logic [SPI_CMD_RSP_W-1:0] head;
    logic                     fifo_full, fifo_empty, pop;

    resp_fifo #(
        .WIDTH (SPI_CMD_RSP_W),
        .DEPTH (FIFO_DEPTH)
    ) u_resp_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (rsp_wr),
        .din   ({rsp_addr, rsp_data}),
        .pop   (pop),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    state_t      state_q, state_d, rst_state;
    logic [5:0]  bit_cnt_q, bit_cnt_d;
    logic [FB-2:0] rx_q, rx_d, tx_q, tx_d;
    logic        miso_q, miso_d, frame_vld_q, frame_vld_d;
    logic [3:0]  cmd_addr_q, cmd_addr_d, cmd_ctrl_q, cmd_ctrl_d;
    logic [23:0] cmd_data_q, cmd_data_d;
    logic        cmd_wr_q, cmd_wr_d, ovf_q, ovf_d, perr_q, perr_d;

    logic [31:0]   miso_word, frame32;
    logic [FB-1:0] tx_load, rx_next;
    logic          par_ok;

    assign rst_state = cs_cur ? IDLE : DONE;
    assign rx_next   = {rx_q, mosi_bit};
    assign frame32   = rx_next[FB-1 -: 32];

    always_comb begin
        miso_word                     = '0;
        miso_word[SPI_CMD_MISO_VALID] = ~fifo_empty;
        miso_word[SPI_CMD_MISO_OVF]   = ovf_q;
        miso_word[SPI_CMD_MISO_PERR]  = perr_q;
        miso_word[27:0]               = fifo_empty ? '0 : head;
    end

`ifdef SPI_CMD_PARITY_EN
    assign tx_load = {miso_word, ^miso_word};
    assign par_ok  = ~(^rx_next);
`else
    assign tx_load = miso_word;
    assign par_ok  = 1'b1;
`endif

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        rx_d        = rx_q;
        tx_d        = tx_q;
        miso_d      = miso_q;
        frame_vld_d = frame_vld_q;
        cmd_addr_d  = cmd_addr_q;
        cmd_ctrl_d  = cmd_ctrl_q;
        cmd_data_d  = cmd_data_q;
        cmd_wr_d    = 1'b0;
        ovf_d       = ovf_q;
        perr_d      = perr_q;
        pop         = 1'b0;
        case (state_q)
            IDLE: begin
                miso_d = 1'b0;
                if (cs_fall) begin
                    tx_d        = tx_load[FB-2:0];
                    miso_d      = tx_load[FB-1];
                    frame_vld_d = ~fifo_empty;
                    bit_cnt_d   = '0;
                    state_d     = SHIFT;
                end
            end
            SHIFT: begin
                if (cs_rise) begin
                    miso_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    if (sck_fall) begin
                        miso_d = tx_q[FB-2];
                        tx_d   = {tx_q[FB-3:0], 1'b0};
                    end
                    if (sck_rise) begin
                        rx_d      = rx_next[FB-2:0];
                        bit_cnt_d = bit_cnt_q + 6'd1;
                        if (bit_cnt_q == 6'(FB - 1)) begin
                            state_d = DONE;
                            miso_d  = 1'b0;
                            if (par_ok) begin
                                cmd_addr_d = frame32[31:28];
                                cmd_ctrl_d = frame32[27:24];
                                cmd_data_d = frame32[23:0];
                                cmd_wr_d   = (frame32[31:28] != SPI_CMD_ADDR_NOP);
                                pop        = frame_vld_q;
                                if (frame32[31:28] == SPI_CMD_ADDR_NOP &&
                                    frame32[27:24] == SPI_CMD_CTRL_CLRFLAGS) begin
                                    ovf_d  = 1'b0;
                                    perr_d = 1'b0;
                                end
                            end else begin
                                perr_d = 1'b1;
                            end
                        end
                    end
                end
            end
            DONE: begin
                miso_d = 1'b0;
                if (cs_rise) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // A drop in the same cycle as a clear-flags command still leaves the flag set.
        if (rsp_wr && fifo_full && !pop) ovf_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= rst_state;
            bit_cnt_q   <= '0;
            rx_q        <= '0;
            tx_q        <= '0;
            miso_q      <= 1'b0;
            frame_vld_q <= 1'b0;
            cmd_addr_q  <= '0;
            cmd_ctrl_q  <= '0;
            cmd_data_q  <= '0;
            cmd_wr_q    <= 1'b0;
            ovf_q       <= 1'b0;
            perr_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            rx_q        <= rx_d;
            tx_q        <= tx_d;
            miso_q      <= miso_d;
            frame_vld_q <= frame_vld_d;
            cmd_addr_q  <= cmd_addr_d;
            cmd_ctrl_q  <= cmd_ctrl_d;
            cmd_data_q  <= cmd_data_d;
            cmd_wr_q    <= cmd_wr_d;
            ovf_q       <= ovf_d;
            perr_q      <= perr_d;
        end
    end

    assign spi_miso = miso_q;
    assign cmd_addr = cmd_addr_q;
    assign cmd_ctrl = cmd_ctrl_q;
    assign cmd_data = cmd_data_q;
    assign cmd_wr   = cmd_wr_q;
    assign fifo_ovf = ovf_q;

endmodule

// File: tb/tb_spi_cmd_slave.sv
// Bench for spi_cmd_slave: SPI host driver, reply pusher, queue-based reference model,
// and independent monitors for cmd_wr strobes and MISO frames.
module tb_spi_cmd_slave;
    localparam int DEPTH = 8;
    localparam int SYNC  = 2;
`ifdef SPI_CMD_PARITY_EN
    localparam int FB = 33;
`else
    localparam int FB = 32;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        spi_cs = 1'b1;
    logic        spi_clk = 1'b0;
    logic        spi_mosi = 1'b0;
    logic        spi_miso;
    logic [3:0]  cmd_addr, cmd_ctrl;
    logic [23:0] cmd_data;
    logic        cmd_wr;
    logic [3:0]  rsp_addr = '0;
    logic [23:0] rsp_data = '0;
    logic        rsp_wr = 1'b0;
    logic        fifo_ovf;

    spi_cmd_slave #(.FIFO_DEPTH(DEPTH), .SYNC_STAGES(SYNC)) dut (
        .clk      (clk),
        .rst      (rst),
        .spi_cs   (spi_cs),
        .spi_clk  (spi_clk),
        .spi_mosi (spi_mosi),
        .spi_miso (spi_miso),
        .cmd_addr (cmd_addr),
        .cmd_ctrl (cmd_ctrl),
        .cmd_data (cmd_data),
        .cmd_wr   (cmd_wr),
        .rsp_addr (rsp_addr),
        .rsp_data (rsp_data),
        .rsp_wr   (rsp_wr),
        .fifo_ovf (fifo_ovf)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          chk;
        logic [FB-1:0] w;
    } miso_exp_t;

    int          errs = 0;
    int          checks = 0;
    logic [27:0] model_q[$];
    logic        m_ovf = 1'b0;
    logic        m_perr = 1'b0;
    logic [31:0] exp_cmd_q[$];
    miso_exp_t   exp_miso_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic void model_push(input logic [27:0] pw);
        if (model_q.size() < DEPTH) model_q.push_back(pw);
        else m_ovf = 1'b1;
    endfunction

    // cmd_wr monitor
    always @(negedge clk) begin
        if (cmd_wr === 1'b1) begin
            if (exp_cmd_q.size() == 0) check("unexpected cmd_wr", 64'd1, 64'd0);
            else check("cmd_word", {cmd_addr, cmd_ctrl, cmd_data}, exp_cmd_q.pop_front());
        end
    end

    // MISO monitor: samples on SCK rise like the host does, compares on CS rise
    initial begin
        int            cnt;
        logic [FB-1:0] sh;
        miso_exp_t     e;
        cnt = 0;
        sh  = '0;
        forever begin
            @(posedge spi_clk or posedge spi_cs);
            if (spi_cs === 1'b1) begin
                if (cnt >= FB) begin
                    if (exp_miso_q.size() == 0) check("unexpected miso frame", 64'd1, 64'd0);
                    else begin
                        e = exp_miso_q.pop_front();
                        if (e.chk) check("miso_frame", sh, e.w);
                    end
                end
                cnt = 0;
            end else begin
                if (cnt < FB) sh = {sh[FB-2:0], spi_miso};
                cnt++;
            end
        end
    end

    task automatic push(input logic [27:0] pw);
        @(negedge clk);
        rsp_addr = pw[27:24];
        rsp_data = pw[23:0];
        rsp_wr   = 1'b1;
        @(negedge clk);
        rsp_wr   = 1'b0;
        model_push(pw);
    endtask

    task automatic frame(input logic [31:0] w, input int nbits, input logic bad_par,
                         input int rst_after, input logic push_commit, input logic [27:0] pw);
        logic [FB-1:0] tx;
        logic [31:0]   m;
        logic          v;
        miso_exp_t     e;
        v = (model_q.size() > 0);
        m = {v, m_ovf, m_perr, 1'b0, v ? model_q[0] : 28'h0};
`ifdef SPI_CMD_PARITY_EN
        tx  = {w, (^w) ^ bad_par};
        e.w = {m, ^m};
`else
        tx  = w;
        e.w = m;
`endif
        e.chk = (rst_after < 0);
        if (nbits >= FB) exp_miso_q.push_back(e);
        if (nbits >= FB && rst_after < 0) begin
            if (!bad_par) begin
                if (w[31:28] != 4'hF) exp_cmd_q.push_back(w);
                if (v) void'(model_q.pop_front());
                if (w[31:24] == 8'hF1) begin
                    m_ovf  = 1'b0;
                    m_perr = 1'b0;
                end
            end else begin
                m_perr = 1'b1;
            end
            if (push_commit) model_push(pw);
        end

        @(negedge clk);
        spi_cs = 1'b0;
        repeat (4) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            spi_mosi = (i < FB) ? tx[FB-1-i] : 1'($urandom);
            repeat (4) @(negedge clk);
            spi_clk = 1'b1;
            if (push_commit && i == FB - 1) begin
                // lands the push on the same clk edge as the commit pop
                repeat (SYNC) @(negedge clk);
                rsp_addr = pw[27:24];
                rsp_data = pw[23:0];
                rsp_wr   = 1'b1;
                @(negedge clk);
                rsp_wr   = 1'b0;
                repeat (4 - SYNC - 1) @(negedge clk);
            end else begin
                repeat (4) @(negedge clk);
            end
            spi_clk = 1'b0;
            if (i + 1 == rst_after) begin
                @(negedge clk);
                rst = 1'b1;
                repeat (4) @(negedge clk);
                rst = 1'b0;
                model_q.delete();
                m_ovf  = 1'b0;
                m_perr = 1'b0;
                @(negedge clk);
                check("rst cmd_wr", cmd_wr, 0);
                check("rst cmd fields", {cmd_addr, cmd_ctrl, cmd_data}, 0);
                check("rst fifo_ovf", fifo_ovf, 0);
            end
        end
        repeat (4) @(negedge clk);
        spi_cs = 1'b1;
        repeat (8) @(negedge clk);
        check("cmd queue drained", exp_cmd_q.size(), 0);
        check("fifo_ovf", fifo_ovf, m_ovf);
    endtask

    initial begin
        logic [31:0] w;
        int          np, r, nb;
        repeat (6) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset cmd_wr", cmd_wr, 0);
        check("reset cmd_addr", cmd_addr, 0);
        check("reset cmd_ctrl", cmd_ctrl, 0);
        check("reset cmd_data", cmd_data, 0);
        check("reset fifo_ovf", fifo_ovf, 0);
        check("reset spi_miso", spi_miso, 0);

        // write command, empty FIFO
        frame(32'h3200ABCD, FB, 1'b0, -1, 1'b0, '0);
        // poll returns reply, then FIFO reads empty
        push(28'h5123456);
        frame(32'hF0000000, FB, 1'b0, -1, 1'b0, '0);
        frame(32'hF0000000, FB, 1'b0, -1, 1'b0, '0);
        // abort after 20 bits keeps the reply
        push(28'h1AAAAAA);
        frame(32'h41000001, 20, 1'b0, -1, 1'b0, '0);
        check("abort no pop", model_q.size(), 1);
        frame(32'hF0000000, FB, 1'b0, -1, 1'b0, '0);
        // overflow
        for (int k = 0; k < DEPTH + 1; k++) push(28'h2000000 + 28'(k));
        @(negedge clk);
        check("ovf after 9 pushes", fifo_ovf, 1);
        frame(32'hF0000000, FB, 1'b0, -1, 1'b0, '0);
        frame(32'hF1000000, FB, 1'b0, -1, 1'b0, '0);
        check("ovf cleared", fifo_ovf, 0);
        // refill to full, then push and pop together
        push(28'h3000001);
        push(28'h3000002);
        frame(32'h27ABCDEF, FB, 1'b0, -1, 1'b1, 28'hC0FFEE1);
        check("no ovf on push+pop", fifo_ovf, 0);
        for (int k = 0; k < DEPTH + 1; k++) frame(32'hF0000000, FB, 1'b0, -1, 1'b0, '0);
        // reset mid-frame
        push(28'h9000001);
        frame(32'h63111111, FB, 1'b0, 10, 1'b0, '0);
        frame(32'h74222222, FB, 1'b0, -1, 1'b0, '0);
`ifdef SPI_CMD_PARITY_EN
        push(28'hA000005);
        frame(32'h85333333, FB, 1'b1, -1, 1'b0, '0);
        frame(32'hF0000000, FB, 1'b0, -1, 1'b0, '0);
        frame(32'hF1000000, FB, 1'b0, -1, 1'b0, '0);
`endif
        // randomized traffic
        for (int n = 0; n < 40; n++) begin
            np = $urandom_range(0, 3);
            for (int k = 0; k < np; k++) push(28'($urandom));
            w = $urandom;
            if ($urandom_range(0, 3) == 0) w[31:28] = 4'hF;
            if ($urandom_range(0, 5) == 0) w[27:24] = 4'h1;
            r = $urandom_range(0, 9);
            if (r == 0) nb = $urandom_range(1, FB - 1);
            else if (r == 1) nb = FB + $urandom_range(1, 3);
            else nb = FB;
            frame(w, nb, 1'b0, -1, 1'b0, '0);
        end

        repeat (10) @(negedge clk);
        check("cmd expectations consumed", exp_cmd_q.size(), 0);
        check("miso expectations consumed", exp_miso_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/spi_cmd_slave.md
# spi_cmd_slave

SPI slave command bridge: an external host (MCU) acts as SPI master and this block turns its frames into the on-chip write-channel pulses (`cmd_addr/cmd_ctrl/cmd_data/cmd_wr`) that drive the peripheral SPI-master wrappers. It also queues their read-channel results (`rsp_*`) in a FIFO and returns them on MISO in later frames. It sits between the host SPI pins and the peripheral address decoder.

## Interface
Parameters:
- `FIFO_DEPTH`, 8: response FIFO entries; power of two, 2..64.
- `SYNC_STAGES`, 2: synchronizer flops on `spi_cs`, `spi_clk` and `spi_mosi`; minimum 2.

Ports:
- `clk` in 1: system clock; the block uses only this clock.
- `rst` in 1: synchronous, active-high reset.
- `spi_cs` in 1: host chip select, active low, asynchronous to `clk`.
- `spi_clk` in 1: host SCK, mode 0, at most `clk`/8.
- `spi_mosi` in 1: host data, MSB first.
- `spi_miso` out 1: reply data, MSB first; reset value 0.
- `cmd_addr` out 4: target peripheral; reset value 0.
- `cmd_ctrl` out 4: peripheral control code; reset value 0.
- `cmd_data` out 24: write payload; reset value 0.
- `cmd_wr` out 1: one-cycle strobe; reset value 0.
- `rsp_addr` in 4: source peripheral of a reply.
- `rsp_data` in 24: reply payload.
- `rsp_wr` in 1: push request, one cycle per reply.
- `fifo_ovf` out 1: sticky flag, set when a reply is dropped; reset value 0.

## Operation
- **MOSI frame:** 32 bits, `{addr[3:0], ctrl[3:0], data[23:0]}`.
- **MISO frame:** 32 bits, `{valid, ovf, perr, 1'b0, addr[3:0], data[23:0]}`.
  - `valid`=1 when the FIFO head is loaded into the frame.
  - If the FIFO is empty, `valid`, `addr` and `data` are all 0.
- **Edge detection:** an edge is taken from the last two synchronized samples.
  - SCK rise: sample MOSI.
  - SCK fall: shift MISO.
  - CS fall: start a frame.
  - CS rise: end the frame.
- **States:**
  - `IDLE`: on CS fall, load the MISO shift register from the FIFO head (no pop yet), drive its MSB, clear the bit counter, go to `SHIFT`.
  - `SHIFT`: count SCK rises. On the 32nd rise, go to `DONE` and commit (see next bullet). On CS rise before 32 bits, abort: no `cmd_wr`, no pop, back to `IDLE`.
  - `DONE`: ignore further SCK edges; drive `spi_miso` 0. On CS rise, go to `IDLE`.
- **Commit on the 32nd rise:**
  - Latch the `cmd_*` fields.
  - Pulse `cmd_wr`, except when `addr`=4'hF (NOP/poll).
  - Pop the FIFO if the frame was `valid`.
  - `addr`=4'hF with `ctrl`=4'h1 also clears `fifo_ovf` and `perr`.
- **Response FIFO:**
  - Stores 28 bits, `{rsp_addr, rsp_data}`.
  - `rsp_wr` while full: the word is dropped and `fifo_ovf` is set.
  - `rsp_wr` together with a pop: both take effect. A full FIFO accepts the push in that case.
  - Pointers are `log2(FIFO_DEPTH)+1` bits and wrap naturally.
- **Reset:** clears the FIFO, the flags and all `cmd_*` outputs.
  - If `spi_cs` is low when reset releases, go to `DONE`. The partial frame is discarded.
- Bits clocked after the 32nd within one CS-low window are ignored.

## Timing
- Input to internal edge: `SYNC_STAGES`+1 `clk` cycles.
- `cmd_wr` is asserted exactly one cycle, on the cycle after the 32nd SCK rise is detected.
  - `cmd_addr/ctrl/data` become valid in that same cycle and hold until the next commit.
- The FIFO pop takes effect on the same cycle as `cmd_wr`.
- A word pushed by `rsp_wr` is visible to the next frame whose CS fall is detected at least 1 cycle after the push.
- MISO:
  - The MSB appears `SYNC_STAGES`+1 cycles after CS falls.
  - Each following bit appears the same delay after each SCK fall.
  - Requires `spi_clk` ≤ `clk`/8 for a valid MISO setup at the host.
- Back-to-back frames need CS high for at least 4 `clk` cycles.

## Configuration
- `SPI_CMD_PARITY_EN` defined:
  - Frames grow to 33 bits. The final MOSI bit is even parity over the 32 data bits; the final MISO bit is even parity over the 32 MISO bits.
  - A mismatch suppresses `cmd_wr` and the pop, and sets sticky `perr`.
  - Commit moves to the 33rd rise.
- Undefined: 32-bit frames; `perr` is constant 0.

## Structure
- Shared package holds:
  - `SPI_CMD_FRAME_BITS` (32/33).
  - `SPI_CMD_ADDR_NOP`=4'hF and `SPI_CMD_CTRL_CLRFLAGS`=4'h1.
  - MISO field offsets (valid 31, ovf 30, perr 29).
  - The state enum `IDLE/SHIFT/DONE`.
- Sub-module `resp_fifo`: synchronous FIFO with parameters width and depth; outputs `full` and `empty`; first-word fall-through head.

## Test plan
- **Write command:** frame 32'h3_2_00ABCD, FIFO empty → one `cmd_wr` with addr 3, ctrl 2, data 24'h00ABCD; MISO reads 32'h0.
- **Poll:** push `rsp` (5, 24'h123456), then frame 32'hF0000000 → MISO 32'h85123456; no `cmd_wr`; FIFO empty afterwards.
- **Abort:** push one reply, raise CS after 20 bits → no `cmd_wr`, no pop; next full frame returns the same reply with `valid`=1.
- **Overflow:**
  - Push 9 replies with `FIFO_DEPTH`=8 → `fifo_ovf`=1 and the 9th is lost; a poll frame shows bit 30 set.
  - Frame 32'hF1000000 then clears the flag.
- **Simultaneous push and pop** while the FIFO is full → count stays 8; no overflow.
- **Reset mid-frame:** assert `rst` after bit 10 with CS still low → no `cmd_wr` for that frame; the next full frame decodes correctly. With `SPI_CMD_PARITY_EN`, a wrong parity bit → no `cmd_wr` and `perr`=1.
